// File: rtl/one_wire_slave_rx_frame_pkg.sv
// one_wire_pkg: shared FSM encoding, CRC-8 polynomial and timing helper for the 1-Wire slave receiver.
package one_wire_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PDH_WAIT,
    S_PDL_DRIVE,
    S_SLOT_WAIT,
    S_SAMPLE,
    S_SLOT_END
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h8C;

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned mhz);
    return us * mhz;
  endfunction
endpackage

// File: rtl/one_wire_slave_rx_frame_crc8.sv
// one_wire_crc8: serial bit-in Dallas/Maxim CRC-8 (reflected, init 0), built only with ONE_WIRE_RX_CRC_EN.
`ifdef ONE_WIRE_RX_CRC_EN
module one_wire_crc8
  import one_wire_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;
  logic       w_fb;
  assign w_fb  = r_crc[0] ^ i_bit;
  assign o_crc = r_crc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_crc <= '0;
    else if (i_clr) r_crc <= '0;
    else if (i_en) r_crc <= {1'b0, r_crc[7:1]} ^ (w_fb ? CRC_POLY : 8'h00);
  end
endmodule
`endif

// File: rtl/one_wire_slave_rx_frame.sv
// one_wire_slave_rx_frame: 1-Wire slave reset/presence responder and LSB-first frame receiver.
// Optional CRC-8 frame check enabled by defining ONE_WIRE_RX_CRC_EN.
module one_wire_slave_rx_frame
  import one_wire_pkg::*;
#(
  parameter int unsigned CLK_MHZ       = 100,
  parameter int unsigned T_RSTL_MIN_US = 480,
  parameter int unsigned T_PDH_US      = 15,
  parameter int unsigned T_PDL_US      = 60,
  parameter int unsigned T_RDS_US      = 15,
  parameter int unsigned FRAME_BYTES   = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  inout  wire        one_wire_data,
  output logic       presence_detect,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic [3:0] rx_byte_idx,
  output logic       rx_frame_done,
  output logic       rx_abort,
  output logic       crc_ok
);
  localparam logic [CNT_W-1:0] RSTL_CYC = CNT_W'(us_to_cyc(T_RSTL_MIN_US, CLK_MHZ));
  localparam logic [CNT_W-1:0] PDH_END  = CNT_W'(us_to_cyc(T_PDH_US, CLK_MHZ) - 1);
  localparam logic [CNT_W-1:0] PDL_END  = CNT_W'(us_to_cyc(T_PDL_US, CLK_MHZ) - 1);
  localparam logic [CNT_W-1:0] RDS_CYC  = CNT_W'(us_to_cyc(T_RDS_US, CLK_MHZ));
  localparam logic [3:0]       LAST_IDX = 4'(FRAME_BYTES - 1);

  state_t           r_state, w_next;
  logic             r_s1, r_s2, r_prev;
  logic [CNT_W-1:0] r_timer, r_low_cnt;
  logic [2:0]       r_bit_idx;
  logic [6:0]       r_shift;
  logic [3:0]       r_byte_idx;
  logic             r_any_bit;
  logic             r_rx_valid, r_frame_done, r_abort;
  logic [7:0]       r_rx_byte;
  logic [3:0]       r_rx_byte_idx;
  logic             w_bus, w_fall, w_rise, w_rst_seen, w_rst_go, w_sample;
  logic             w_drive, w_last_bit, w_last_byte, w_tmr_run;

  // Anything other than a hard 0 (Z/X/1) is treated as a released bus
  assign w_bus         = (one_wire_data !== 1'b0);
  assign w_drive       = (r_state == S_PDL_DRIVE);
  assign one_wire_data = w_drive ? 1'b0 : 1'bz;
  assign w_fall        = r_prev & ~r_s2;
  assign w_rise        = ~r_prev & r_s2;
  assign w_rst_seen    = (r_low_cnt == RSTL_CYC);
  assign w_last_bit    = (r_bit_idx == 3'd7);
  assign w_last_byte   = (r_byte_idx == LAST_IDX);
  assign w_tmr_run     = (r_state == S_PDH_WAIT) || (r_state == S_PDL_DRIVE) || (r_state == S_SAMPLE);

  assign presence_detect = w_drive;
  assign rx_valid        = r_rx_valid;
  assign rx_byte         = r_rx_byte;
  assign rx_byte_idx     = r_rx_byte_idx;
  assign rx_frame_done   = r_frame_done;
  assign rx_abort        = r_abort;

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_rst_go = enable && w_rise && w_rst_seen && (r_state != S_PDH_WAIT) && (r_state != S_PDL_DRIVE);
    case (r_state)
      S_PDH_WAIT:  if (r_timer == PDH_END) w_next = S_PDL_DRIVE;
      S_PDL_DRIVE: if (r_timer == PDL_END) w_next = S_SLOT_WAIT;
      S_SLOT_WAIT: if (w_fall) w_next = S_SAMPLE;
      S_SAMPLE: if (r_timer == RDS_CYC) begin
        w_sample = 1'b1;
        w_next   = (w_last_bit && w_last_byte) ? S_IDLE : S_SLOT_END;
      end
      S_SLOT_END:  if (r_s2) w_next = S_SLOT_WAIT;
      default: ;
    endcase
    if (w_rst_go) w_next = S_PDH_WAIT;
    if (w_rst_go || !enable) w_sample = 1'b0;
    if (!enable) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1          <= 1'b1;
      r_s2          <= 1'b1;
      r_prev        <= 1'b1;
      r_timer       <= '0;
      r_low_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_byte_idx    <= '0;
      r_any_bit     <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_frame_done  <= 1'b0;
      r_abort       <= 1'b0;
      r_rx_byte     <= '0;
      r_rx_byte_idx <= '0;
    end else begin
      r_s1         <= w_bus;
      r_s2         <= r_s1;
      r_prev       <= r_s2;
      r_rx_valid   <= w_sample && w_last_bit;
      r_frame_done <= w_sample && w_last_bit && w_last_byte;
      r_abort      <= w_rst_go && r_any_bit;
      r_timer      <= (!w_tmr_run || w_next != r_state) ? '0 : r_timer + 1'b1;
      r_low_cnt    <= (!enable || r_s2) ? '0 : (!w_drive && !w_rst_seen) ? r_low_cnt + 1'b1 : r_low_cnt;
      if (!enable || w_rst_go || w_drive) begin
        r_bit_idx  <= '0;
        r_byte_idx <= '0;
        r_any_bit  <= 1'b0;
      end else if (w_sample) begin
        r_shift   <= {r_s2, r_shift[6:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
        r_any_bit <= !(w_last_bit && w_last_byte);
        if (w_last_bit) begin
          r_rx_byte     <= {r_s2, r_shift};
          r_rx_byte_idx <= r_byte_idx;
          r_byte_idx    <= r_byte_idx + 1'b1;
        end
      end
    end
  end

`ifdef ONE_WIRE_RX_CRC_EN
  logic [7:0] w_crc;
  logic       r_crc_valid;
  one_wire_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_drive),
    .i_en  (w_sample),
    .i_bit (r_s2),
    .o_crc (w_crc)
  );
  // CRC register settles on the same edge that raises rx_frame_done and is frozen until the next presence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_crc_valid <= 1'b0;
    else if (w_drive) r_crc_valid <= 1'b0;
    else if (w_sample && w_last_bit && w_last_byte) r_crc_valid <= 1'b1;
  end
  assign crc_ok = r_crc_valid && (w_crc == 8'h00);
`else
  assign crc_ok = 1'b0;
`endif
endmodule

// File: tb/tb_one_wire_slave_rx_frame.sv
// tb_one_wire_slave_rx_frame: directed table-driven bench; FRAME_BYTES=1 and FRAME_BYTES=2 slaves on twin buses at 1 MHz.
module tb_one_wire_slave_rx_frame;
  localparam int RSTL = 480;
  localparam int PDL  = 60;
  // 2-flop synchroniser + edge-detect register before the FSM starts counting tPDH
  localparam int PRES_LAT = 15 + 3;
`ifdef ONE_WIRE_RX_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, m_low = 1'b0;
  wire  bus_a, bus_b;
  assign bus_a = m_low ? 1'b0 : 1'bz;
  assign bus_b = m_low ? 1'b0 : 1'bz;
  pullup (bus_a);
  pullup (bus_b);

  logic       pres_a, val_a, done_a, abort_a, crc_a;
  logic       pres_b, val_b, done_b, abort_b, crc_b;
  logic [7:0] byte_a, byte_b;
  logic [3:0] idx_a, idx_b;

  one_wire_slave_rx_frame #(.CLK_MHZ(1), .FRAME_BYTES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .one_wire_data(bus_a),
    .presence_detect(pres_a), .rx_valid(val_a), .rx_byte(byte_a), .rx_byte_idx(idx_a),
    .rx_frame_done(done_a), .rx_abort(abort_a), .crc_ok(crc_a)
  );
  one_wire_slave_rx_frame #(.CLK_MHZ(1), .FRAME_BYTES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .one_wire_data(bus_b),
    .presence_detect(pres_b), .rx_valid(val_b), .rx_byte(byte_b), .rx_byte_idx(idx_b),
    .rx_frame_done(done_b), .rx_abort(abort_b), .crc_ok(crc_b)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; logic [3:0] idx; logic done; logic crc; } evt_t;
  typedef struct { logic [7:0] b0; logic [7:0] b1; logic crc_a; logic crc_b; } vec_t;

  evt_t qa[$], qb[$];
  int   ab_a = 0, ab_b = 0, pres_cnt = 0, done_only = 0;
  int   checks = 0, errors = 0;

  always @(negedge clk) begin
    if (val_a) qa.push_back('{byte_a, idx_a, done_a, crc_a});
    if (val_b) qb.push_back('{byte_b, idx_b, done_b, crc_b});
    if ((done_a && !val_a) || (done_b && !val_b)) done_only++;
    if (abort_a) ab_a++;
    if (abort_b) ab_b++;
    if (pres_a || pres_b) pres_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    qa.delete();
    qb.delete();
    ab_a = 0;
    ab_b = 0;
    pres_cnt = 0;
    done_only = 0;
  endtask

  task automatic master_low(input int n);
    m_low = 1'b1;
    tick(n);
    m_low = 1'b0;
  endtask

  task automatic send_bit(input bit v);
    m_low = 1'b1;
    tick(v ? 6 : 60);
    m_low = 1'b0;
    tick(v ? 64 : 10);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic reset_presence(input string tag);
    int  lat, width;
    bit  bus_ok;
    master_low(RSTL);
    lat = 0;
    while (!pres_a && lat < 200) begin
      tick(1);
      lat++;
    end
    width  = 0;
    bus_ok = 1'b1;
    while (pres_a && width < 200) begin
      if (bus_a !== 1'b0 || bus_b !== 1'b0 || pres_b !== 1'b1) bus_ok = 1'b0;
      tick(1);
      width++;
    end
    chk({tag, "_pres_latency"}, lat, PRES_LAT);
    chk({tag, "_pres_width"}, width, PDL);
    chk({tag, "_pres_bus_low"}, bus_ok, 1);
    tick(10);
  endtask

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // hand-computed Dallas CRC-8: crc(0x01)=0x5E, crc(0xA5)=0x90, crc(0x00)=0x00
    vecs[0] = '{8'hA5, 8'h90, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 8'h5E, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h5F, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 1'b0, 1'b0};

    tick(3);
    chk("reset_outputs_a", {pres_a, val_a, byte_a, idx_a, done_a, abort_a, crc_a}, 0);
    chk("reset_outputs_b", {pres_b, val_b, byte_b, idx_b, done_b, abort_b, crc_b}, 0);
    chk("reset_bus_released", {bus_a, bus_b}, 2'b11);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick(5);

    for (int v = 0; v < 5; v++) begin
      reset_presence($sformatf("v%0d", v));
      clear_mon();
      send_byte(vecs[v].b0);
      send_byte(vecs[v].b1);
      tick(5);
      chk($sformatf("v%0d_a_count", v), qa.size(), 1);
      if (qa.size() >= 1)
        chk($sformatf("v%0d_a_evt", v), {qa[0].b, qa[0].idx, qa[0].done, qa[0].crc},
            {vecs[v].b0, 4'd0, 1'b1, CRC_EN & vecs[v].crc_a});
      chk($sformatf("v%0d_b_count", v), qb.size(), 2);
      if (qb.size() >= 2) begin
        chk($sformatf("v%0d_b_evt0", v), {qb[0].b, qb[0].idx, qb[0].done, qb[0].crc},
            {vecs[v].b0, 4'd0, 1'b0, 1'b0});
        chk($sformatf("v%0d_b_evt1", v), {qb[1].b, qb[1].idx, qb[1].done, qb[1].crc},
            {vecs[v].b1, 4'd1, 1'b1, CRC_EN & vecs[v].crc_b});
      end
      chk($sformatf("v%0d_hold", v), {byte_a, byte_b, crc_a, crc_b},
          {vecs[v].b0, vecs[v].b1, CRC_EN & vecs[v].crc_a, CRC_EN & vecs[v].crc_b});
      chk($sformatf("v%0d_no_abort", v), ab_a + ab_b + done_only, 0);
    end

    // short lows in IDLE, including one cycle below the reset threshold
    clear_mon();
    master_low(100);
    tick(100);
    send_byte(8'hFF);
    master_low(RSTL - 1);
    tick(150);
    chk("short_no_presence", pres_cnt, 0);
    chk("short_no_rx", qa.size() + qb.size(), 0);
    reset_presence("after_short");

    // partial second byte interrupted by a master reset
    reset_presence("abort_setup");
    clear_mon();
    send_byte(8'h3C);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_presence("abort");
    chk("abort_a_count", qa.size(), 1);
    if (qa.size() >= 1) chk("abort_a_evt", {qa[0].b, qa[0].idx, qa[0].done}, {8'h3C, 4'd0, 1'b1});
    chk("abort_b_count", qb.size(), 1);
    if (qb.size() >= 1) chk("abort_b_evt", {qb[0].b, qb[0].idx, qb[0].done}, {8'h3C, 4'd0, 1'b0});
    chk("abort_pulses", {ab_a[7:0], ab_b[7:0]}, {8'd0, 8'd1});

    // enable dropped for one cycle mid-presence
    begin
      int w;
      master_low(RSTL);
      w = 0;
      while (!pres_a && w < 200) begin
        tick(1);
        w++;
      end
      chk("en_pres_seen", pres_a, 1);
      tick(20);
      enable = 1'b0;
      tick(1);
      chk("en_released", {pres_a, pres_b, bus_a, bus_b}, 4'b0011);
      enable = 1'b1;
      tick(100);
      clear_mon();
      send_byte(8'h00);
      send_byte(8'h5A);
      tick(5);
      chk("en_no_rx", qa.size() + qb.size(), 0);
      chk("en_no_presence", pres_cnt, 0);
      reset_presence("en_recover");
      clear_mon();
      send_byte(8'h01);
      send_byte(8'h5E);
      tick(5);
      chk("en_recover_rx", qb.size(), 2);
      if (qb.size() >= 2) chk("en_recover_b1", {qb[1].b, qb[1].idx, qb[1].done}, {8'h5E, 4'd1, 1'b1});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
